// File: rtl/mips_pkg.sv
// Shared MIPS core constants: opcode/funct/REGIMM encodings used by the
// write-back stage, plus the PC value reported before the first commit.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;

  localparam logic [5:0] FN_JALR   = 6'h09;

  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/load_extend.sv
// Load data extractor for the W stage.
// Ports:
//   w_op      in   6  opcode of the W-stage instruction
//   addr      in   2  low bits of the load effective address
//   w_dm_out  in  32  raw aligned data-memory word
//   ext_out   out 32  selected byte/half/word, sign- or zero-extended
// Non-load opcodes pass the raw word through; the top decides whether to use it.
module load_extend
  import mips_pkg::*;
(
  input  logic [5:0]  w_op,
  input  logic [1:0]  addr,
  input  logic [31:0] w_dm_out,
  output logic [31:0] ext_out
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = w_dm_out[7:0];
    case (addr)
      2'd0:    w_byte = w_dm_out[7:0];
      2'd1:    w_byte = w_dm_out[15:8];
      2'd2:    w_byte = w_dm_out[23:16];
      default: w_byte = w_dm_out[31:24];
    endcase
    // Halfword loads ignore addr[0].
    w_half = addr[1] ? w_dm_out[31:16] : w_dm_out[15:0];

    case (w_op)
      OP_LB:   ext_out = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  ext_out = {24'h0, w_byte};
      OP_LH:   ext_out = {{16{w_half[15]}}, w_half};
      OP_LHU:  ext_out = {16'h0, w_half};
      default: ext_out = w_dm_out;
    endcase
  end

endmodule

// File: rtl/grf_writeback.sv
// W-stage write-back and 32x32 general register file.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   w_pc, w_op, w_fuc,    W-stage instruction fields
//   w_rt, w_a3
//   w_alu_ans, w_dm_out   ALU result / load address, raw memory word
//   w_cmp                 branch outcome, gates bltzal/bgezal link
//   d_a1, d_a2            D-stage read addresses
//   d_rd1, d_rd2          combinational read data with write-through bypass
//   commit_*              registered trace of the previous cycle's write
module grf_writeback #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] w_pc,
  input  logic [5:0]  w_op,
  input  logic [5:0]  w_fuc,
  input  logic [4:0]  w_rt,
  input  logic [4:0]  w_a3,
  input  logic [31:0] w_alu_ans,
  input  logic [31:0] w_dm_out,
  input  logic        w_cmp,
  input  logic [4:0]  d_a1,
  input  logic [4:0]  d_a2,
  output logic [31:0] d_rd1,
  output logic [31:0] d_rd2,
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  output logic [31:0] commit_data,
  output logic [4:0]  commit_addr
);
  import mips_pkg::*;

  logic [31:0] r_grf [32];

  logic [31:0] w_ld_data;
  logic [31:0] w_wdata;
  logic        w_regimm_link;
  logic        w_is_link;
  logic        w_is_load;
  logic        w_we;

  load_extend u_load_extend (
    .w_op     (w_op),
    .addr     (w_alu_ans[1:0]),
    .w_dm_out (w_dm_out),
    .ext_out  (w_ld_data)
  );

  always_comb begin
    w_regimm_link = (w_op == OP_REGIMM) && ((w_rt == RT_BLTZAL) || (w_rt == RT_BGEZAL));
    w_is_link     = (w_op == OP_JAL) || ((w_op == OP_RTYPE) && (w_fuc == FN_JALR)) ||
                    w_regimm_link;
    w_is_load     = (w_op == OP_LW) || (w_op == OP_LB) || (w_op == OP_LBU) ||
                    (w_op == OP_LH) || (w_op == OP_LHU);

    if (w_is_link)      w_wdata = w_pc + 32'd8;
    else if (w_is_load) w_wdata = w_ld_data;
    else                w_wdata = w_alu_ans;

    // A not-taken bltzal/bgezal still carries its rd field; suppress the link.
    w_we = (w_a3 != 5'd0) && (!w_regimm_link || w_cmp);
  end

  // Write-through bypass lets D read a value committing on this very edge.
  always_comb begin
    if (d_a1 == 5'd0)                 d_rd1 = 32'h0;
    else if (w_we && (d_a1 == w_a3))  d_rd1 = w_wdata;
    else                              d_rd1 = r_grf[d_a1];

    if (d_a2 == 5'd0)                 d_rd2 = 32'h0;
    else if (w_we && (d_a2 == w_a3))  d_rd2 = w_wdata;
    else                              d_rd2 = r_grf[d_a2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_grf[i] <= 32'h0;
      commit_valid <= 1'b0;
      commit_addr  <= 5'd0;
      commit_data  <= 32'h0;
      commit_pc    <= RESET_PC;
    end else begin
      commit_valid <= w_we;
      if (w_we) begin
        r_grf[w_a3] <= w_wdata;
        commit_addr <= w_a3;
        commit_data <= w_wdata;
        commit_pc   <= w_pc;
      end
    end
  end

endmodule
